// File: rtl/aes_pkg.sv
// Shared AES-128 types, constants and pure round-transform helpers.
// State bytes are held column-major: element 0 is the MSB byte (FIPS-197 byte 0),
// byte index = row + 4*column.
package aes_pkg;

  localparam int         NR_AES128  = 10;
  localparam logic [7:0] RCON_INIT  = 8'h01;
  localparam logic [7:0] XTIME_POLY = 8'h1b;

  typedef logic [7:0]        aes_byte_t;
  typedef logic [0:3][7:0]   aes_word_t;
  typedef logic [0:15][7:0]  aes_state_t;

  typedef enum logic [1:0] {IDLE, ROUND, DONE} aes_fsm_t;

  // Multiply by x in GF(2^8), reducing modulo x^8+x^4+x^3+x+1.
  function automatic aes_byte_t xtime(input aes_byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? XTIME_POLY : 8'h00);
  endfunction

  // Row r is rotated left by r byte positions.
  function automatic aes_state_t shift_rows(input aes_state_t s);
    aes_state_t o;
    o = s;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        o[r + 4*c] = s[r + 4*((c + r) % 4)];
      end
    end
    return o;
  endfunction

  // Each column multiplied by the fixed {02,03,01,01} circulant matrix.
  function automatic aes_state_t mix_columns(input aes_state_t s);
    aes_state_t o;
    aes_byte_t  a0, a1, a2, a3;
    o = s;
    for (int c = 0; c < 4; c++) begin
      a0 = s[4*c];
      a1 = s[4*c + 1];
      a2 = s[4*c + 2];
      a3 = s[4*c + 3];
      o[4*c]     = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[4*c + 1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[4*c + 2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[4*c + 3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_key_step.sv
// One AES-128 key-schedule step: rk -> next round key using rcon.
module aes_key_step
  import aes_pkg::*;
(
  input  aes_state_t rk,
  input  aes_byte_t  rcon,
  output aes_state_t rk_next
);

  aes_word_t w3_rot;
  aes_word_t w3_sub;
  aes_word_t temp;
  aes_word_t n0, n1, n2, n3;

  assign w3_rot = {rk[13], rk[14], rk[15], rk[12]};

  for (genvar gi = 0; gi < 4; gi++) begin : g_subword
    aes_sbox u_sbox (.a(w3_rot[gi]), .y(w3_sub[gi]));
  end

  assign temp    = w3_sub ^ {rcon, 24'h000000};
  assign n0      = rk[0:3]   ^ temp;
  assign n1      = rk[4:7]   ^ n0;
  assign n2      = rk[8:11]  ^ n1;
  assign n3      = rk[12:15] ^ n2;
  assign rk_next = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_sbox.sv
// AES forward S-box for one byte: GF(2^8) inverse followed by the affine map.
module aes_sbox
  import aes_pkg::*;
(
  input  aes_byte_t a,
  output aes_byte_t y
);

  function automatic aes_byte_t gf_mul(input aes_byte_t x, input aes_byte_t m);
    aes_byte_t acc;
    aes_byte_t p;
    acc = 8'h00;
    p   = x;
    for (int i = 0; i < 8; i++) begin
      if (m[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

  // x^254 is the multiplicative inverse (and maps 0 to 0).
  function automatic aes_byte_t gf_inv(input aes_byte_t x);
    aes_byte_t r;
    aes_byte_t p;
    r = 8'h01;
    p = x;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  aes_byte_t inv;

  // Inverse then affine transform with constant 0x63.
  always_comb begin
    inv = gf_inv(a);
    y   = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
              ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end

endmodule

// File: rtl/aes_subbytes.sv
// SubBytes across the full 16-byte state.
module aes_subbytes
  import aes_pkg::*;
(
  input  aes_state_t s,
  output aes_state_t y
);

  for (genvar gi = 0; gi < 16; gi++) begin : g_sbox
    aes_sbox u_sbox (.a(s[gi]), .y(y[gi]));
  end

endmodule

// File: rtl/aes128_enc_iter.sv
// Iterative AES-128 encryptor: one round per clock, key expanded on the fly.
// Optional macro AES128_ENC_BACK2BACK_EN lets a new block be accepted in the
// same cycle the finished ciphertext is handed off.
module aes128_enc_iter
  import aes_pkg::*;
#(
  parameter int NR                = NR_AES128,
  parameter bit RESET_CLEARS_DATA = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_pt,
  input  logic [127:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_ct
);

  localparam logic [3:0] NR_LAST = 4'(NR);

  aes_fsm_t   fsm_reg, fsm_next;
  aes_state_t state_reg;
  aes_state_t rk_reg;
  aes_byte_t  rcon_reg;
  logic [3:0] rnd_reg;

  aes_state_t sb, sr, mc, rk_next, round_out;
  logic       last_round;
  logic       accept;

  aes_subbytes u_subbytes (.s(state_reg), .y(sb));
  aes_key_step u_key_step (.rk(rk_reg), .rcon(rcon_reg), .rk_next(rk_next));

  assign last_round = (rnd_reg == NR_LAST);
  assign sr         = shift_rows(sb);
  assign mc         = mix_columns(sr);
  assign round_out  = (last_round ? sr : mc) ^ rk_next;
  assign accept     = in_valid & in_ready;
  assign out_ct     = (fsm_reg == DONE) ? 128'(state_reg) : 128'h0;

  // Next-state and handshake outputs.
  always_comb begin
    fsm_next  = fsm_reg;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (fsm_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) fsm_next = ROUND;
      end
      ROUND: begin
        if (last_round) fsm_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
`ifdef AES128_ENC_BACK2BACK_EN
        in_ready = out_ready;
`else
        in_ready = 1'b0;
`endif
        if (out_ready) fsm_next = (in_valid && in_ready) ? ROUND : IDLE;
      end
      default: fsm_next = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) fsm_reg <= IDLE;
    else     fsm_reg <= fsm_next;
  end

  // Cipher state, round key, rcon and round counter; load on accept, advance in ROUND.
  always_ff @(posedge clk) begin
    if (rst) begin
      rnd_reg  <= 4'd0;
      rcon_reg <= RCON_INIT;
      if (RESET_CLEARS_DATA) begin
        state_reg <= '0;
        rk_reg    <= '0;
      end
    end else if (accept) begin
      state_reg <= aes_state_t'(in_pt ^ in_key);
      rk_reg    <= aes_state_t'(in_key);
      rcon_reg  <= RCON_INIT;
      rnd_reg   <= 4'd1;
    end else if (fsm_reg == ROUND) begin
      state_reg <= round_out;
      rk_reg    <= rk_next;
      rcon_reg  <= xtime(rcon_reg);
      // Counter parks at 0 once the final round is done so it never passes NR.
      rnd_reg   <= last_round ? 4'd0 : rnd_reg + 4'd1;
    end
  end

endmodule

// File: tb/tb_aes128_enc_iter.sv
// Self-checking bench for aes128_enc_iter against a byte-array AES-128 model.
module tb_aes128_enc_iter;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, out_valid, out_ready;
  logic [127:0] in_pt, in_key, out_ct;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]   sb_tab [256];
  logic [127:0] q_pt[$], q_key[$], q_ct[$];
  int           q_acyc[$], q_ocyc[$];

  localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P1 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C1 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P2 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C2 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
`ifdef AES128_ENC_BACK2BACK_EN
  localparam int EXP_GAP = 11;
`else
  localparam int EXP_GAP = 12;
`endif

  aes128_enc_iter dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_pt(in_pt), .in_key(in_key),
    .out_valid(out_valid), .out_ready(out_ready), .out_ct(out_ct)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r, x, y;
    r = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) r = r ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return r;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, b, c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        b[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sb_tab[x] = b;
    end
  endtask

  function automatic logic [127:0] ref_enc(input logic [127:0] pt, input logic [127:0] key);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [31:0]  tmp;
    logic [127:0] res;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sb_tab[tmp[31:24]], sb_tab[tmp[23:16]], sb_tab[tmp[15:8]], sb_tab[tmp[7:0]]}
              ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int j = 0; j < 16; j++) s[j] = pt[127-8*j -: 8] ^ w[j/4][31-8*(j%4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int j = 0; j < 16; j++) t[j] = sb_tab[s[j]];
      for (int row = 0; row < 4; row++)
        for (int col = 0; col < 4; col++)
          s[row + 4*col] = t[row + 4*((col + row) % 4)];
      if (r < 10) begin
        for (int col = 0; col < 4; col++) begin
          a0 = s[4*col]; a1 = s[4*col+1]; a2 = s[4*col+2]; a3 = s[4*col+3];
          s[4*col]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4*col+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4*col+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4*col+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
      end
      for (int j = 0; j < 16; j++) s[j] = s[j] ^ w[4*r + j/4][31-8*(j%4) -: 8];
    end
    for (int j = 0; j < 16; j++) res[127-8*j -: 8] = s[j];
    return res;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    q_pt.delete(); q_key.delete(); q_ct.delete(); q_acyc.delete(); q_ocyc.delete();
  endtask

  // Feed queued blocks, collect ciphertexts at each output handshake.
  task automatic stream(input int n_blocks, input bit rand_ready);
    int  budget;
    int  got;
    bit  fire_in, fire_out;
    budget = 40 * n_blocks + 60;
    got    = 0;
    while (got < n_blocks && budget > 0) begin
      out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (q_pt.size() > 0) begin
        in_valid = 1'b1; in_pt = q_pt[0]; in_key = q_key[0];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      fire_in  = in_valid & in_ready;
      fire_out = out_valid & out_ready;
      if (fire_out) begin
        q_ct.push_back(out_ct);
        q_ocyc.push_back(cyc);
        $display("txn out #%0d ct=%h cyc=%0d", got, out_ct, cyc);
        got++;
      end
      if (fire_in) begin
        q_acyc.push_back(cyc + 1);
        $display("txn in  pt=%h key=%h cyc=%0d", q_pt[0], q_key[0], cyc + 1);
        void'(q_pt.pop_front());
        void'(q_key.pop_front());
      end
      step();
      budget--;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("stream_done_count", 128'(got), 128'(n_blocks));
  endtask

  initial begin
    logic [127:0] pa, ka, exp_ct;
    int k, seen;
    build_sbox();
    rst = 1'b1; in_valid = 1'b0; in_pt = '0; in_key = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready",  128'(in_ready),  128'd1);
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_out_ct",    out_ct,          128'd0);
    rst = 1'b0;
    step();

    // FIPS-197 Appendix B with latency
    clear_q(); q_pt.push_back(P1); q_key.push_back(K1);
    stream(1, 1'b0);
    check("fips_b_ct", q_ct[0], C1);
    check("fips_b_latency", 128'(q_ocyc[0] - q_acyc[0]), 128'd10);

    // FIPS-197 Appendix C.1
    clear_q(); q_pt.push_back(P2); q_key.push_back(K2);
    stream(1, 1'b0);
    check("fips_c1_ct", q_ct[0], C2);

    // Backpressure: result held for 20 cycles
    out_ready = 1'b0; in_valid = 1'b1; in_pt = P1; in_key = K1;
    step();
    in_valid = 1'b0;
    $display("txn in  pt=%h key=%h cyc=%0d (backpressure)", P1, K1, cyc);
    k = 0;
    while (k < 15 && !out_valid) begin step(); k++; end
    check("bp_out_valid", 128'(out_valid), 128'd1);
    check("bp_ct", out_ct, C1);
    for (int i = 0; i < 20; i++) begin
      step();
      check("bp_hold_valid", 128'(out_valid), 128'd1);
      check("bp_hold_ct", out_ct, C1);
      check("bp_hold_in_ready", 128'(in_ready), 128'd0);
    end
    out_ready = 1'b1;
    step();
    $display("txn out ct=%h released cyc=%0d", C1, cyc);
    check("bp_after_valid", 128'(out_valid), 128'd0);
    check("bp_after_in_ready", 128'(in_ready), 128'd1);
    check("bp_after_ct", out_ct, 128'd0);

    // Reset 5 cycles after accept aborts the block
    in_valid = 1'b1; in_pt = P1; in_key = K1;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    $display("txn reset mid-op cyc=%0d", cyc);
    check("abort_out_valid", 128'(out_valid), 128'd0);
    check("abort_in_ready",  128'(in_ready),  128'd1);
    check("abort_out_ct",    out_ct,          128'd0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin step(); if (out_valid) seen++; end
    check("abort_no_emit", 128'(seen), 128'd0);
    clear_q(); q_pt.push_back(P2); q_key.push_back(K2);
    stream(1, 1'b0);
    check("abort_rerun_ct", q_ct[0], C2);

    // in_valid held during ROUND with a different plaintext is ignored
    pa = {$urandom, $urandom, $urandom, $urandom};
    ka = {$urandom, $urandom, $urandom, $urandom};
    in_valid = 1'b1; in_pt = pa; in_key = ka;
    step();
    $display("txn in  pt=%h key=%h cyc=%0d (held valid)", pa, ka, cyc);
    in_pt = ~pa;
    for (int i = 0; i < 8; i++) begin
      step();
      check("held_in_ready", 128'(in_ready), 128'd0);
    end
    in_valid = 1'b0;
    k = 0;
    while (k < 15 && !out_valid) begin step(); k++; end
    exp_ct = ref_enc(pa, ka);
    $display("txn out ct=%h cyc=%0d", out_ct, cyc);
    check("held_out_valid", 128'(out_valid), 128'd1);
    check("held_ct", out_ct, exp_ct);
    step();
    check("held_after_valid", 128'(out_valid), 128'd0);

    // Streaming two vectors: spacing depends on back-to-back support
    clear_q();
    q_pt.push_back(P1); q_key.push_back(K1);
    q_pt.push_back(P2); q_key.push_back(K2);
    stream(2, 1'b0);
    check("stream_ct0", q_ct[0], C1);
    check("stream_ct1", q_ct[1], C2);
    check("stream_gap", 128'(q_ocyc[1] - q_ocyc[0]), 128'(EXP_GAP));

    // Random blocks with random backpressure against the model
    clear_q();
    for (int i = 0; i < 6; i++) begin
      q_pt.push_back({$urandom, $urandom, $urandom, $urandom});
      q_key.push_back({$urandom, $urandom, $urandom, $urandom});
    end
    begin
      logic [127:0] exp_q[$];
      for (int i = 0; i < 6; i++) exp_q.push_back(ref_enc(q_pt[i], q_key[i]));
      stream(6, 1'b1);
      for (int i = 0; i < 6; i++)
        check("rand_ct", (i < q_ct.size()) ? q_ct[i] : 128'hx, exp_q[i]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/aes128_enc_iter.md
Name: aes128_enc_iter

Overview:
Iterative AES-128 encryption engine. It holds the 128-bit cipher state in a register and feeds it, one round per clock, through the team's existing subbytes/sbox datapath, then ShiftRows, MixColumns and AddRoundKey. Round keys are expanded on the fly, one per cycle. It sits between the block-level input FIFO and the ciphertext output stage, and uses valid/ready handshakes on both sides.

Parameters:
NR, 10, number of rounds (fixed for AES-128; other values are unsupported).
RESET_CLEARS_DATA, 1, when 1 a reset also zeroes the state and key registers; when 0 only control state is reset.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  a plaintext/key pair is presented.
in_ready  output  1  engine can accept a block.
in_pt  input  128  plaintext; [127:120] = byte 0 (FIPS-197 column-major order).
in_key  input  128  cipher key, same byte order.
out_valid  output  1  ciphertext is available.
out_ready  input  1  downstream accepts the ciphertext.
out_ct  output  128  ciphertext, same byte order.

Behaviour:
- One clock (clk). Reset rst is synchronous and active-high.
- Reset values: in_ready=1, out_valid=0, out_ct=0, FSM=IDLE, round counter=0, rcon=8'h01.
- FSM IDLE:
  - in_ready=1.
  - On in_valid&in_ready at edge k: state<=in_pt^in_key; rk<=in_key; rcon<=8'h01; rnd<=1; go to ROUND.
- FSM ROUND:
  - in_ready=0.
  - Each edge: rk_next=KeyStep(rk,rcon); state<=MC(SR(SB(state)))^rk_next, with MC omitted when rnd==NR.
  - Each edge: rk<=rk_next; rcon<=xtime(rcon) (8'h80 -> 8'h1b); rnd<=rnd+1.
  - When rnd==NR: go to DONE.
- FSM DONE:
  - out_valid=1; out_ct=state; in_ready=0.
  - On out_valid&out_ready: go to IDLE, out_valid drops next cycle.
  - out_ct and out_valid hold stable while out_ready=0 (no timeout).
- Latency: accept at edge k, out_valid high after edge k+NR (10 cycles). Throughput is 1 block per 12 cycles without the optional feature.
- out_ct is driven from the state register only in DONE; it is 0 otherwise. No combinational path from in_* to out_*.
- Input ignored: in_valid while in_ready=0 has no effect. in_pt/in_key are sampled only at the accept edge.
- Reset mid-operation: rst in ROUND or DONE aborts immediately. Next cycle is IDLE with reset values; the partial result is never emitted.
- rst has priority over every handshake in the same cycle.
- Round counter is 4 bits and never exceeds NR.

Optional Feature:
AES128_ENC_BACK2BACK_EN
- Defined: in DONE, in_ready=out_ready. A simultaneous output handshake and input accept at the same edge moves DONE directly to ROUND with the new block loaded. Throughput becomes 1 block per 11 cycles.
- Undefined: in_ready=0 in DONE; a new block is accepted only from IDLE.

Decomposition:
- Package aes_pkg:
  - NR_AES128=10.
  - FSM state typedef {IDLE, ROUND, DONE}.
  - RCON_INIT=8'h01 and the xtime reduction constant 8'h1b.
  - Byte/word typedefs (aes_byte_t, aes_word_t, aes_state_t).
  - Pure functions xtime, shift_rows, mix_columns.
- Sub-modules:
  - aes_key_step, combinational: RotWord, SubWord via 4 sbox instances, rcon XOR, word chaining. Maps (rk, rcon) -> rk_next.
  - Round datapath reuses the existing subbytes module.

Test Plan:
1. FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734, out_ready=1 -> out_ct=3925841d02dc09fbdc118597196a0b32, out_valid exactly 10 cycles after accept.
2. FIPS-197 App. C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> out_ct=69c4e0d86a7b0430d8cdb78070b4c55a.
3. Backpressure: out_ready=0 for 20 cycles after vector 1 completes -> out_valid and out_ct stable, in_ready=0; release -> single handshake, then IDLE.
4. Reset mid-operation: assert rst 5 cycles after accept -> next cycle out_valid=0, in_ready=1. Re-run vector 2 -> correct ciphertext.
5. in_valid held high in ROUND with a different pt -> ignored; out_ct matches only the first block.
6. With AES128_ENC_BACK2BACK_EN defined: vectors 1 and 2 streamed with out_ready=1 -> ciphertexts 11 cycles apart, both correct. Without the macro -> 12 cycles apart.
